// File: rtl/nn_pkg.sv
// Shared types and constants for the dense-layer sequencer and its operand pipe.
// Build option: define RELU_EN to clamp negative neuron results to zero.
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int Q_FRAC = 10;

    localparam logic [3:0] MAC_CTRL_LOAD = 4'b1111;
    localparam logic [3:0] MAC_CTRL_ACC  = 4'b0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] z);
        return z[DATA_W-1] ? '0 : z;
    endfunction

endpackage

// File: rtl/nn_operand_pipe.sv
// Aligns the address-phase request flags with 1-cycle-latency memory data and
// zero-gates the MAC operands whenever no data phase is active.
module nn_operand_pipe
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              acc_req,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] mac_in,
    output logic [DATA_W-1:0] mac_w,
    output logic [3:0]        mac_ctrl
);

    logic load_q;
    logic acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= 1'b0;
            acc_q  <= 1'b0;
        end else begin
            load_q <= load_req;
            acc_q  <= acc_req;
        end
    end

    // Operands of zero with ACC ctrl leave the MAC accumulator untouched.
    always_comb begin
        mac_in   = acc_q ? in_data : '0;
        mac_w    = acc_q ? w_data  : '0;
        mac_ctrl = load_q ? MAC_CTRL_LOAD : MAC_CTRL_ACC;
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Drives one shared MAC through a dense layer: bias load, N_IN accumulates, drain, write.
// Build option: RELU_EN clamps negative results written to the output buffer.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 4,
    parameter int IN_AW  = 4,
    parameter int W_AW   = 8,
    parameter int OUT_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [OUT_AW-1:0] b_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] mac_in,
    output logic [DATA_W-1:0] mac_w,
    output logic [3:0]        mac_ctrl,
    input  logic [DATA_W-1:0] mac_zout,
    output logic              out_wr_en,
    output logic [OUT_AW-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output state_t            dbg_state
);

    localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [IN_AW-1:0]    k;
    logic [OUT_AW-1:0]   j;
    logic [W_AW-1:0]     wa;
    logic                load_req;
    logic                acc_req;

    // Handshake: start is a level sampled only in IDLE; busy covers BIAS..WRITE,
    // done is a single-cycle pulse in DONE; nothing is queued while busy.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = BIAS;
            BIAS:    state_nxt = ACC;
            ACC:     if (k == K_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   state_nxt = (j == J_LAST) ? DONE : BIAS;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wa runs across neurons so it always equals j*N_IN+k without a multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            j  <= '0;
            k  <= '0;
            wa <= '0;
        end else begin
            case (state)
                ACC: begin
                    wa <= wa + 1'b1;
                    k  <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                WRITE: if (j != J_LAST) j <= j + 1'b1;
                DONE: begin
                    j  <= '0;
                    wa <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = state inside {BIAS, ACC, DRAIN, WRITE};
        done      = (state == DONE);
        out_wr_en = (state == WRITE);
        load_req  = (state == BIAS);
        acc_req   = (state == ACC);
        out_data  = '0;
        if (state == WRITE) begin
`ifdef RELU_EN
            out_data = relu(mac_zout);
`else
            out_data = mac_zout;
`endif
        end
    end

    assign in_addr   = k;
    assign w_addr    = wa;
    assign b_addr    = j;
    assign out_addr  = j;
    assign dbg_state = state;

    nn_operand_pipe u_operand_pipe (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .acc_req  (acc_req),
        .in_data  (in_data),
        .w_data   (w_data),
        .mac_in   (mac_in),
        .mac_w    (mac_w),
        .mac_ctrl (mac_ctrl)
    );

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with memory and MAC models around it.
// Expected neuron results come from a hand-computed table; RELU_EN selects the clamped column.
module tb_nn_layer_sequencer;
  import nn_pkg::*;

  localparam int N_IN     = 4;
  localparam int N_OUT    = 4;
  localparam int IN_AW    = 4;
  localparam int W_AW     = 8;
  localparam int OUT_AW   = 4;
  localparam int NPH      = N_IN + 3;
  localparam int DONE_CYC = N_OUT * NPH + 1;
  localparam int CYC_MAX  = 200;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic [OUT_AW-1:0] b_addr;
  logic [15:0]       in_data;
  logic [15:0]       w_data;
  logic [15:0]       mac_in;
  logic [15:0]       mac_w;
  logic [3:0]        mac_ctrl;
  logic [15:0]       mac_zout;
  logic              out_wr_en;
  logic [OUT_AW-1:0] out_addr;
  logic [15:0]       out_data;
  state_t            dbg_state;

  nn_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .w_addr(w_addr), .b_addr(b_addr),
    .in_data(in_data), .w_data(w_data),
    .mac_in(mac_in), .mac_w(mac_w), .mac_ctrl(mac_ctrl), .mac_zout(mac_zout),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory + MAC models ----------------
  logic [15:0]        in_mem[16];
  logic [15:0]        w_mem[256];
  logic [31:0]        b_mem[16];
  logic [31:0]        b_q;
  logic signed [32:0] acc;

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_q     <= b_mem[b_addr];
    if (mac_ctrl == 4'b1111)
      acc <= {b_q[31], b_q};
    else
      acc <= acc + ($signed({{17{mac_in[15]}}, mac_in}) * $signed({{17{mac_w[15]}}, mac_w}));
  end
  assign mac_zout = acc[25:10];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", {out_addr, out_data}, 20'hFFFFF);
      else check("write", {out_addr, out_data}, exp_q.pop_front());
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] bias;
    logic [15:0] exp_plain;
    logic [15:0] exp_relu;
  } vec_t;
  vec_t tbl[8];

  task automatic load_layer(input int layer, input int n_exp);
    for (int kk = 0; kk < N_IN; kk++)
      in_mem[kk] = (layer == 0) ? 16'd1024 : 16'(1024 * (kk + 1));
    for (int jj = 0; jj < N_OUT; jj++) begin
      for (int kk = 0; kk < N_IN; kk++)
        w_mem[jj * N_IN + kk] = (layer == 0) ? 16'd1024 : 16'(512 * (jj + 1));
      b_mem[jj] = tbl[layer * N_OUT + jj].bias;
      if (jj < n_exp) begin
`ifdef RELU_EN
        exp_q.push_back({4'(jj), tbl[layer * N_OUT + jj].exp_relu});
`else
        exp_q.push_back({4'(jj), tbl[layer * N_OUT + jj].exp_plain});
`endif
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_phase(input int cyc);
    int p;
    int jn;
    p  = (cyc - 1) % NPH;
    jn = (cyc - 1) / NPH;
    if (p == 0) begin
      check("b_addr", b_addr, jn);
      check("busy", busy, 1);
    end
    if (p >= 1 && p <= N_IN) begin
      check("in_addr", in_addr, p - 1);
      check("w_addr", w_addr, jn * N_IN + p - 1);
    end
    if (p == 1) begin
      check("ctrl_load", mac_ctrl, 4'hF);
      check("load_ops", {mac_in, mac_w}, 0);
    end
    if (p >= 2 && p <= N_IN + 1) begin
      check("ctrl_acc", mac_ctrl, 4'h0);
      check("mac_in", mac_in, in_mem[p - 2]);
      check("mac_w", mac_w, w_mem[jn * N_IN + p - 2]);
    end
  endtask

  task automatic run_layer(input int restart_cyc);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!done && cyc < CYC_MAX) begin
      if (cyc < DONE_CYC) check_phase(cyc);
      start = (cyc == restart_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, DONE_CYC);
    check("busy_at_done", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] zsave;
    int cyc;
    tbl[0] = '{32'h0000_0000, 16'h1000, 16'h1000};
    tbl[1] = '{32'hFF80_0000, 16'hF000, 16'h0000};
    tbl[2] = '{32'h0010_0000, 16'h1400, 16'h1400};
    tbl[3] = '{32'h0030_0000, 16'h1C00, 16'h1C00};
    tbl[4] = '{32'h0010_0000, 16'h1800, 16'h1800};
    tbl[5] = '{32'hFF00_0000, 16'hE800, 16'h0000};
    tbl[6] = '{32'h0000_0000, 16'h3C00, 16'h3C00};
    tbl[7] = '{32'h0010_0000, 16'h5400, 16'h5400};
    for (int i = 0; i < 16; i++) begin in_mem[i] = '0; b_mem[i] = '0; end
    for (int i = 0; i < 256; i++) w_mem[i] = '0;
    acc   = '0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_flags", {busy, done, out_wr_en}, 0);
    check("rst_addrs", {in_addr, w_addr, b_addr, out_addr}, 0);
    check("rst_mac", {mac_ctrl, mac_in, mac_w}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // Layer A: unit inputs/weights, per-neuron biases.
    load_layer(0, N_OUT);
    run_layer(0);

    // Layer B: ramp inputs, per-neuron weights, extra start pulse mid-layer.
    load_layer(1, N_OUT);
    run_layer(10);

    // start during DONE is ignored; then idle hold leaves MAC alone.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    zsave = mac_zout;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", {busy, mac_ctrl, mac_in, mac_w, mac_zout}, {1'b0, 4'h0, 32'h0, zsave});
    end
    check("writes_after_b", wr_cnt, 2 * N_OUT);
    check("dones_after_b", done_cnt, 2);

    // Reset in ACC of neuron 1 aborts; only neuron 0 gets written.
    load_layer(0, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_flags", {busy, done, out_wr_en}, 0);
    check("abort_addrs", {in_addr, w_addr, b_addr}, 0);
    check("abort_mac", {mac_ctrl, mac_in, mac_w}, 0);
    repeat (12) @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_writes", wr_cnt, 2 * N_OUT + 1);

    // Full layer after the abort.
    load_layer(0, N_OUT);
    run_layer(0);
    repeat (4) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    check("total_writes", wr_cnt, 3 * N_OUT + 1);
    check("total_dones", done_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
